// File: rtl/op_unit_pkg.sv
// Shared op codes, widths and the round-robin pick used by the op unit scheduler.
// Pure declarations: no state, no latency.
package op_unit_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int RESULT_WIDTH = 9;

  typedef enum logic [1:0] {
    OP_PASS       = 2'b00,
    OP_ADD_TWO    = 2'b01,
    OP_DOUBLE     = 2'b10,
    OP_COUNT_ONES = 2'b11
  } op_e;

  // One-hot pick of the first valid client at or after last+1, wrapping at n (n <= 8).
  function automatic logic [7:0] rr_next_grant(input logic [7:0] valid,
                                               input logic [2:0] last,
                                               input int         n);
    logic found;
    int   idx;
    rr_next_grant = '0;
    found         = 1'b0;
    idx           = 0;
    for (int k = 1; k <= 8; k++) begin
      idx = (int'(last) + k) % n;
      if (!found && (k <= n) && valid[idx[2:0]]) begin
        rr_next_grant[idx[2:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/op_unit_scheduler_result_fifo.sv
// Tagged result buffer: registered head, push visible the cycle after the write (no bypass).
// Push is ignored when full unless a pop frees the slot; pop on empty is ignored.
module result_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop_rdy,
  output logic [WIDTH-1:0]             head_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_rdy && !empty;
    do_push  = push_vld && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/op_unit_scheduler.sv
// Round-robin share of one op unit among clients; accept-to-result_valid is 3 cycles.
// Grants stop while FIFO count plus in-flight ops would reach RESULT_DEPTH (credit backpressure).
module op_unit_scheduler
  import op_unit_pkg::*;
#(
  parameter int REQUESTERS   = 4,
  parameter int RESULT_DEPTH = 4,
  parameter int ID_WIDTH     = 2
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [REQUESTERS-1:0]            request_valid,
  output logic [REQUESTERS-1:0]            request_ready,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] request_in,
  input  logic [REQUESTERS*2-1:0]          request_op,
  output logic [DATA_WIDTH-1:0]            unit_in,
  output logic [1:0]                       unit_op,
  input  logic [RESULT_WIDTH-1:0]          unit_out,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic [ID_WIDTH-1:0]              result_id,
  output logic [RESULT_WIDTH-1:0]          result_data
);

  localparam int CNT_W  = $clog2(RESULT_DEPTH) + 1;
  localparam int FIFO_W = ID_WIDTH + RESULT_WIDTH;

  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] unit_in_q, unit_in_d;
  logic [1:0]            unit_op_q, unit_op_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
  logic [1:0]            s1_op_q, s1_op_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
  logic                  s3_vld_q, s3_vld_d;
  logic [ID_WIDTH-1:0]   s3_id_q, s3_id_d;

  logic [REQUESTERS-1:0] pick;
  logic                  credit_ok;
  logic                  xfer;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [FIFO_W-1:0]     head_dat;

  // Credit check uses the pre-pop count so a same-cycle pop never over-commits.
  always_comb begin
    int occ;
    occ       = int'(fifo_count) + int'(s1_vld_q) + int'(s2_vld_q) + int'(s3_vld_q);
    credit_ok = !fifo_full && (occ < RESULT_DEPTH);
    pick      = REQUESTERS'(rr_next_grant(8'(request_valid), 3'(last_grant_q), REQUESTERS));
    request_ready = credit_ok ? pick : '0;
    xfer      = |(request_valid & request_ready);
    gnt_id    = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (request_ready[i]) gnt_id = ID_WIDTH'(i);
    end
  end

  // Operand goes out at the grant edge, its op one edge later; stages carry the tag to the FIFO.
  always_comb begin
    last_grant_d = xfer ? gnt_id : last_grant_q;
    unit_in_d    = xfer ? request_in[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH] : unit_in_q;
    s1_vld_d     = xfer;
    s1_id_d      = gnt_id;
    s1_op_d      = request_op[int'(gnt_id)*2 +: 2];
    unit_op_d    = s1_vld_q ? s1_op_q : unit_op_q;
    s2_vld_d     = s1_vld_q;
    s2_id_d      = s1_id_q;
    s3_vld_d     = s2_vld_q;
    s3_id_d      = s2_id_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= ID_WIDTH'(REQUESTERS - 1);
      unit_in_q    <= '0;
      unit_op_q    <= '0;
      s1_vld_q     <= 1'b0;
      s1_id_q      <= '0;
      s1_op_q      <= '0;
      s2_vld_q     <= 1'b0;
      s2_id_q      <= '0;
      s3_vld_q     <= 1'b0;
      s3_id_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      unit_in_q    <= unit_in_d;
      unit_op_q    <= unit_op_d;
      s1_vld_q     <= s1_vld_d;
      s1_id_q      <= s1_id_d;
      s1_op_q      <= s1_op_d;
      s2_vld_q     <= s2_vld_d;
      s2_id_q      <= s2_id_d;
      s3_vld_q     <= s3_vld_d;
      s3_id_q      <= s3_id_d;
    end
  end

  assign unit_in = unit_in_q;
  assign unit_op = unit_op_q;

  result_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RESULT_DEPTH)
  ) u_result_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push_vld (s3_vld_q),
    .push_dat ({s3_id_q, unit_out}),
    .pop_rdy  (result_valid && result_ready),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign result_valid = !fifo_empty;
  assign result_id    = head_dat[FIFO_W-1:RESULT_WIDTH];
  assign result_data  = head_dat[RESULT_WIDTH-1:0];

endmodule

// File: tb/tb_op_unit_scheduler.sv
// Directed bench for op_unit_scheduler with a behavioural op unit (operand capture, then registered result).
module tb_op_unit_scheduler;
  import op_unit_pkg::*;

  localparam int N = 4;

  logic           clock   = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   request_valid;
  logic [N-1:0]   request_ready;
  logic [N*8-1:0] request_in;
  logic [N*2-1:0] request_op;
  logic [7:0]     unit_in;
  logic [1:0]     unit_op;
  logic [8:0]     unit_out;
  logic           result_valid;
  logic           result_ready;
  logic [1:0]     result_id;
  logic [8:0]     result_data;

  always #5 clock = ~clock;

  op_unit_scheduler #(
    .REQUESTERS   (N),
    .RESULT_DEPTH (4),
    .ID_WIDTH     (2)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .request_valid (request_valid),
    .request_ready (request_ready),
    .request_in    (request_in),
    .request_op    (request_op),
    .unit_in       (unit_in),
    .unit_op       (unit_op),
    .unit_out      (unit_out),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_id     (result_id),
    .result_data   (result_data)
  );

  function automatic logic [8:0] op_eval(input logic [7:0] a, input logic [1:0] op);
    case (op)
      OP_PASS:    op_eval = {1'b0, a};
      OP_ADD_TWO: op_eval = {1'b0, a} + 9'd2;
      OP_DOUBLE:  op_eval = {a, 1'b0};
      default:    op_eval = 9'($countones(a));
    endcase
  endfunction

  // Op unit: captures data one edge, computes with the op present the next edge.
  logic [7:0] ou_in_q;
  logic [8:0] ou_out_q;
  always @(posedge clock) begin
    ou_in_q  <= unit_in;
    ou_out_q <= op_eval(ou_in_q, unit_op);
  end
  assign unit_out = ou_out_q;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int g_id[$];
  int g_cyc[$];
  int r_id[$];
  int r_dat[$];
  int r_cyc[$];

  always @(negedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (request_valid[i] && request_ready[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      if (result_valid && result_ready) begin
        r_id.push_back(int'(result_id));
        r_dat.push_back(int'(result_data));
        r_cyc.push_back(cyc);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_client(input int i, input logic [7:0] d, input logic [1:0] op);
    request_in[i*8 +: 8] = d;
    request_op[i*2 +: 2] = op;
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete();
    r_id.delete(); r_dat.delete(); r_cyc.delete();
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic [7:0] sp_d   [4] = '{8'h10, 8'h0F, 8'h41, 8'h77};
  logic [1:0] sp_op  [4] = '{OP_ADD_TWO, OP_COUNT_ONES, OP_DOUBLE, OP_PASS};
  logic [8:0] sp_exp [4] = '{9'h012, 9'h004, 9'h082, 9'h077};
  logic [8:0] ar_exp [3] = '{9'h101, 9'h1FE, 9'h080};
  logic [1:0] prev_op;

  initial begin
    request_valid = '0;
    request_in    = '0;
    request_op    = '0;
    result_ready  = 1'b1;
    tick();
    tick();
    check_eq("rst_unit_in", unit_in, 0);
    check_eq("rst_unit_op", unit_op, 0);
    check_eq("rst_result_valid", result_valid, 0);
    check_eq("rst_result_id", result_id, 0);
    check_eq("rst_result_data", result_data, 0);
    reset_n = 1'b1;
    tick();

    // Single request, count-ones.
    set_client(2, 8'hFF, OP_COUNT_ONES);
    request_valid = 4'b0100;
    #1;
    check_eq("single_ready", request_ready, 4'b0100);
    tick();
    request_valid = '0;
    check_eq("single_unit_in", unit_in, 8'hFF);
    tick();
    check_eq("single_unit_op", unit_op, OP_COUNT_ONES);
    check_eq("single_no_early_1", result_valid, 0);
    tick();
    check_eq("single_no_early_2", result_valid, 0);
    tick();
    check_eq("single_valid", result_valid, 1);
    check_eq("single_id", result_id, 2);
    check_eq("single_data", result_data, 9'd8);
    tick();
    check_eq("single_popped", result_valid, 0);

    // Back-to-back arithmetic from client 0.
    clear_logs();
    set_client(0, 8'hFF, OP_ADD_TWO);
    request_valid = 4'b0001;
    #1;
    check_eq("arith_ready_a", request_ready, 4'b0001);
    tick();
    set_client(0, 8'hFF, OP_DOUBLE);
    #1;
    check_eq("arith_ready_b", request_ready, 4'b0001);
    tick();
    set_client(0, 8'h80, OP_PASS);
    tick();
    request_valid = '0;
    repeat (6) tick();
    check_eq("arith_count", r_dat.size(), 3);
    if (r_dat.size() == 3) begin
      for (int k = 0; k < 3; k++) check_eq($sformatf("arith_data_%0d", k), r_dat[k], ar_exp[k]);
      check_eq("arith_consec_1", r_cyc[1] - r_cyc[0], 1);
      check_eq("arith_consec_2", r_cyc[2] - r_cyc[1], 1);
    end

    // Fairness with all clients valid.
    reset_pulse();
    clear_logs();
    for (int i = 0; i < N; i++) set_client(i, 8'(8'h11 * (i + 1)), OP_PASS);
    request_valid = 4'b1111;
    repeat (12) tick();
    request_valid = '0;
    repeat (8) tick();
    check_eq("fair_grants_ge6", g_id.size() >= 6, 1);
    check_eq("fair_results_ge6", r_id.size() >= 6, 1);
    if (g_id.size() >= 6 && r_id.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check_eq($sformatf("fair_grant_%0d", k), g_id[k], k % 4);
        check_eq($sformatf("fair_rid_%0d", k), r_id[k], k % 4);
        check_eq($sformatf("fair_rdat_%0d", k), r_dat[k], 8'h11 * (k % 4 + 1));
      end
      check_eq("fair_first4_consec", g_cyc[3] - g_cyc[0], 3);
    end

    // Backpressure: credits cap acceptance at FIFO depth.
    reset_pulse();
    clear_logs();
    result_ready  = 1'b0;
    request_valid = 4'b1111;
    repeat (10) tick();
    check_eq("bp_grants", g_id.size(), 4);
    check_eq("bp_ready_low", request_ready, 0);
    check_eq("bp_head_valid", result_valid, 1);
    check_eq("bp_head_id", result_id, 0);
    check_eq("bp_head_data", result_data, 9'h011);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_eq("bp_regrant", request_ready, 4'b0001);
    tick();
    check_eq("bp_grants_after", g_id.size(), 5);
    check_eq("bp_ready_low_again", request_ready, 0);
    request_valid = '0;
    result_ready  = 1'b1;
    repeat (10) tick();
    check_eq("bp_drained", r_id.size(), 5);
    if (r_id.size() == 5) begin
      for (int k = 0; k < 5; k++) check_eq($sformatf("bp_rid_%0d", k), r_id[k], k % 4);
    end

    // Reset with two buffered and two in flight.
    reset_pulse();
    clear_logs();
    for (int i = 0; i < N; i++) set_client(i, 8'(8'h11 * (i + 1)), OP_DOUBLE);
    result_ready  = 1'b0;
    request_valid = 4'b1111;
    repeat (4) tick();
    request_valid = '0;
    tick();
    check_eq("mid_pre_grants", g_id.size(), 4);
    check_eq("mid_pre_valid", result_valid, 1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_unit_in", unit_in, 0);
    check_eq("mid_unit_op", unit_op, 0);
    check_eq("mid_result_valid", result_valid, 0);
    check_eq("mid_result_id", result_id, 0);
    check_eq("mid_result_data", result_data, 0);
    tick();
    tick();
    reset_n = 1'b1;
    clear_logs();
    result_ready = 1'b1;
    repeat (8) tick();
    check_eq("mid_no_results", r_id.size(), 0);
    request_valid = 4'b1111;
    #1;
    check_eq("mid_first_grant", request_ready, 4'b0001);
    tick();
    request_valid = '0;
    check_eq("mid_grant_count", g_id.size(), 1);
    repeat (6) tick();

    // Sparse requests from client 3, one every third cycle.
    clear_logs();
    prev_op = OP_DOUBLE;
    for (int k = 0; k < 4; k++) begin
      set_client(3, sp_d[k], sp_op[k]);
      request_valid = 4'b1000;
      tick();
      request_valid = '0;
      check_eq($sformatf("sparse_unit_in_%0d", k), unit_in, sp_d[k]);
      check_eq($sformatf("sparse_op_lag_%0d", k), unit_op, prev_op);
      tick();
      check_eq($sformatf("sparse_op_now_%0d", k), unit_op, sp_op[k]);
      prev_op = sp_op[k];
      tick();
    end
    repeat (6) tick();
    check_eq("sparse_count", r_id.size(), 4);
    if (r_id.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check_eq($sformatf("sparse_id_%0d", k), r_id[k], 3);
        check_eq($sformatf("sparse_data_%0d", k), r_dat[k], sp_exp[k]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
